// File: rtl/mem_stage.sv
// RV32 pipeline MEM stage: accepts EX results, performs loads/stores over a req/ack
// data port, and hands the write-back payload to WB. State changes on negedge clk.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_busb,
  input  logic [4:0]  in_rw,
  input  logic [31:0] in_PC,
  input  logic [2:0]  in_MemOp,
  input  logic        in_RegWr,
  input  logic        in_MemtoReg,
  input  logic        in_MemWr,
  input  logic        in_done,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  rw,
  output logic [31:0] PC,
  output logic        RegWr,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [1:0] {EMPTY, ACCESS, FULL, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, busb_q, busb_d, pc_q, pc_d, wb_q, wb_d;
  logic [4:0]  rw_q, rw_d;
  logic [2:0]  memop_q, memop_d;
  logic        regwr_q, regwr_d, ld_q, ld_d, st_q, st_d;
  logic        done_q, done_d, mis_q, mis_d;

  logic        accept, send, in_mem, in_mis;
  logic [31:0] lane, ld_val, wdata_rep;
  logic [3:0]  mask;

  assign out_valid = (state_q == FULL) & !flush;
  assign send      = out_valid & out_ready;
  assign in_ready  = (state_q == EMPTY) | ((state_q == FULL) & send);
  assign accept    = in_valid & in_ready & !flush;

  assign in_mem = in_MemtoReg | in_MemWr;
  assign in_mis = in_mem & (((in_MemOp[1:0] == 2'b01) & in_result[0]) |
                            ((in_MemOp[1:0] == 2'b10) & (in_result[1:0] != 2'b00)));

  // Shift the addressed byte/half down to bit 0 before extension.
  assign lane = dmem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_val = dmem_rdata;
    case (memop_q)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'h0, lane[7:0]};
      3'b101:  ld_val = {16'h0, lane[15:0]};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    mask      = 4'b1111;
    wdata_rep = busb_q;
    case (memop_q[1:0])
      2'b00: begin
        mask      = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{busb_q[7:0]}};
      end
      2'b01: begin
        mask      = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{busb_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Request stays up through DRAIN so an in-flight access still completes.
  assign dmem_req   = (state_q == ACCESS) | (state_q == DRAIN);
  assign dmem_we    = dmem_req & st_q;
  assign dmem_wmask = (dmem_req & st_q) ? mask : 4'b0000;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_rep;

  assign wb_data  = wb_q;
  assign rw       = rw_q;
  assign PC       = pc_q;
  assign RegWr    = regwr_q;
  assign done     = done_q;
  assign misalign = mis_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busb_d  = busb_q;
    pc_d    = pc_q;
    wb_d    = wb_q;
    rw_d    = rw_q;
    memop_d = memop_q;
    regwr_d = regwr_q;
    ld_d    = ld_q;
    st_d    = st_q;
    done_d  = done_q;
    mis_d   = mis_q;
    case (state_q)
      EMPTY:  if (flush) state_d = EMPTY;
      ACCESS: begin
        // An ack arriving with the flush already finished the access; skip DRAIN.
        if (flush) state_d = dmem_ack ? EMPTY : DRAIN;
        else if (dmem_ack) begin
          state_d = FULL;
          if (ld_q && !st_q) wb_d = ld_val;
        end
      end
      FULL:   if (flush || send) state_d = EMPTY;
      DRAIN:  if (dmem_ack) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      addr_d  = in_result;
      busb_d  = in_busb;
      pc_d    = in_PC;
      wb_d    = in_result;
      rw_d    = in_rw;
      memop_d = in_MemOp;
      regwr_d = in_RegWr & !in_mis;
      ld_d    = in_MemtoReg;
      st_d    = in_MemWr;
      done_d  = in_done;
      mis_d   = in_mis;
      state_d = (in_mem && !in_mis) ? ACCESS : FULL;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      busb_q  <= '0;
      pc_q    <= '0;
      wb_q    <= '0;
      rw_q    <= '0;
      memop_q <= '0;
      regwr_q <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busb_q  <= busb_d;
      pc_q    <= pc_d;
      wb_q    <= wb_d;
      rw_q    <= rw_d;
      memop_q <= memop_d;
      regwr_q <= regwr_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake, loads/stores, misalign, flush/drain, reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_result, in_busb, in_PC;
  logic [4:0]  in_rw;
  logic [2:0]  in_MemOp;
  logic        in_RegWr, in_MemtoReg, in_MemWr, in_done;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        out_valid, out_ready;
  logic [31:0] wb_data, PC;
  logic [4:0]  rw;
  logic        RegWr, done, misalign;
  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_busb(in_busb), .in_rw(in_rw), .in_PC(in_PC),
    .in_MemOp(in_MemOp), .in_RegWr(in_RegWr), .in_MemtoReg(in_MemtoReg),
    .in_MemWr(in_MemWr), .in_done(in_done), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .rw(rw), .PC(PC), .RegWr(RegWr),
    .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [31:0] busb, input logic [31:0] pc,
                       input logic [4:0] rwv, input logic [2:0] op,
                       input logic rwr, input logic m2r, input logic mwr);
    in_valid = 1'b1; in_result = res; in_busb = busb; in_PC = pc; in_rw = rwv;
    in_MemOp = op; in_RegWr = rwr; in_MemtoReg = m2r; in_MemWr = mwr; in_done = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(); step();
    tests++; if (out_valid !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_wmask !== 4'h0) begin
      fails++; $display("FAIL reset_ctrl: valid=%b req=%b we=%b mask=%h, required 0", out_valid, dmem_req, dmem_we, dmem_wmask); end
    tests++; if (RegWr !== 1'b0 || done !== 1'b0 || misalign !== 1'b0) begin
      fails++; $display("FAIL reset_flags: RegWr=%b done=%b mis=%b, required 0", RegWr, done, misalign); end
    tests++; if (wb_data !== 32'h0 || rw !== 5'h0 || PC !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_data: wb=%h rw=%h pc=%h addr=%h wdata=%h, required 0", wb_data, rw, PC, dmem_addr, dmem_wdata); end
    tests++; if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(32'h11, 32'h0, 32'h100, 5'd5, 3'b010, 1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b required 1", in_ready); end
    step();
    drive(32'h22, 32'h0, 32'h104, 5'd6, 3'b010, 1'b1, 1'b0, 1'b0);
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'h11 || rw !== 5'd5 || PC !== 32'h100) begin
      fails++; $display("FAIL b2b_first: valid=%b wb=%h rw=%0d pc=%h, required 1 11 5 100", out_valid, wb_data, rw, PC); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b required 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'h22 || rw !== 5'd6) begin
      fails++; $display("FAIL b2b_second: valid=%b wb=%h rw=%0d, required 1 22 6", out_valid, wb_data, rw); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: valid=%b required 0", out_valid); end
  endtask

  task automatic test_lb;
    drive(32'h1003, 32'h0, 32'h200, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F; end
      #1;
      tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h1000 || dmem_wmask !== 4'h0 || dmem_we !== 1'b0) begin
        fails++; $display("FAIL lb_req%0d: req=%b addr=%h mask=%h we=%b, required 1 1000 0 0", i, dmem_req, dmem_addr, dmem_wmask, dmem_we); end
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL lb_wait%0d: valid=%b ready=%b, required 0 0", i, out_valid, in_ready); end
      step();
    end
    dmem_ack = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || dmem_req !== 1'b0 || RegWr !== 1'b1) begin
      fails++; $display("FAIL lb_result: valid=%b wb=%h req=%b RegWr=%b, required 1 ffffff80 0 1", out_valid, wb_data, dmem_req, RegWr); end
    step();
  endtask

  task automatic test_lhu_lh;
    drive(32'h2002, 32'h0, 32'h300, 5'd8, 3'b101, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_1234;
    step();
    dmem_ack = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'h0000_BEEF) begin
      fails++; $display("FAIL lhu_result: valid=%b wb=%h, required 1 0000beef", out_valid, wb_data); end
    step();
    drive(32'h6002, 32'h0, 32'h304, 5'd9, 3'b001, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    step();
    dmem_ack = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'hFFFF_8001) begin
      fails++; $display("FAIL lh_result: valid=%b wb=%h, required 1 ffff8001", out_valid, wb_data); end
    step();
  endtask

  task automatic test_sh;
    drive(32'h3002, 32'h0000_CAFE, 32'h400, 5'd10, 3'b001, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wmask !== 4'b1100 || dmem_wdata !== 32'hCAFE_CAFE || dmem_addr !== 32'h3000) begin
      fails++; $display("FAIL sh_req: req=%b we=%b mask=%b wdata=%h addr=%h, required 1 1 1100 cafecafe 3000", dmem_req, dmem_we, dmem_wmask, dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'h3002 || RegWr !== 1'b1 || misalign !== 1'b0) begin
      fails++; $display("FAIL sh_result: valid=%b wb=%h RegWr=%b mis=%b, required 1 3002 1 0", out_valid, wb_data, RegWr, misalign); end
    step();
  endtask

  task automatic test_misalign;
    drive(32'h4001, 32'h0, 32'h500, 5'd11, 3'b010, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b0 || out_valid !== 1'b1 || misalign !== 1'b1 || RegWr !== 1'b0) begin
      fails++; $display("FAIL mis_lw: req=%b valid=%b mis=%b RegWr=%b, required 0 1 1 0", dmem_req, out_valid, misalign, RegWr); end
    tests++; if (wb_data !== 32'h4001) begin fails++; $display("FAIL mis_wb: got %h required 4001", wb_data); end
    step();
  endtask

  task automatic test_flush_full;
    drive(32'h77, 32'h0, 32'h600, 5'd12, 3'b010, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_full_gate: valid=%b ready=%b, required 0 0", out_valid, in_ready); end
    step();
    flush = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_full_empty: valid=%b ready=%b, required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_flush_drain;
    drive(32'h5000, 32'h0, 32'h700, 5'd13, 3'b010, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'h99, 32'h0, 32'h704, 5'd14, 3'b010, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL drain_flush: req=%b ready=%b, required 1 0", dmem_req, in_ready); end
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; end
      #1;
      tests++; if (dmem_req !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL drain_hold%0d: req=%b ready=%b valid=%b, required 1 0 0", i, dmem_req, in_ready, out_valid); end
      step();
    end
    dmem_ack = 1'b0; out_ready = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== 32'h5000) begin
      fails++; $display("FAIL drain_done: req=%b valid=%b ready=%b wb=%h, required 0 0 1 5000", dmem_req, out_valid, in_ready, wb_data); end
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || wb_data !== 32'h99 || in_ready !== 1'b0) begin
      fails++; $display("FAIL drain_full: valid=%b wb=%h ready=%b, required 1 99 0", out_valid, wb_data, in_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || dmem_req !== 1'b0 || wb_data !== 32'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_full: valid=%b req=%b wb=%h ready=%b, required 0 0 0 1", out_valid, dmem_req, wb_data, in_ready); end
    drive(32'h8000, 32'h0, 32'h800, 5'd15, 3'b010, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rst_access_pre: req=%b required 1", dmem_req); end
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || dmem_addr !== 32'h0) begin
      fails++; $display("FAIL rst_access: req=%b valid=%b addr=%h, required 0 0 0", dmem_req, out_valid, dmem_addr); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_busb = '0; in_PC = '0;
    in_rw = '0; in_MemOp = '0; in_RegWr = 1'b0; in_MemtoReg = 1'b0; in_MemWr = 1'b0;
    in_done = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0; out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_lb();
    test_lhu_lh();
    test_sh();
    test_misalign();
    test_flush_full();
    test_flush_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
